// File: rtl/quad_gen.sv
// Quadrature A/B decoder (x4): synchronize, optionally filter, then count Gray steps.
// Latency SYNC_STAGES+1 clocks input edge to count (filter adds FILTER_LEN-1); no backpressure, free-running.
module quad_gen #(
    parameter int WIDTH       = 22,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             quadA,
    input  logic             quadB,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic                   sa;
    logic                   sb;
    logic                   cur_a;
    logic                   cur_b;
    logic [1:0]             prev;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], quadA};
            sync_b <= {sync_b[SYNC_STAGES-2:0], quadB};
        end
    end

    assign sa = sync_a[SYNC_STAGES-1];
    assign sb = sync_b[SYNC_STAGES-1];

    generate
        if (FILTER_LEN > 1) begin : g_filt
            logic [FILTER_LEN-2:0] hist_a;
            logic [FILTER_LEN-2:0] hist_b;
            logic                  acc_a;
            logic                  acc_b;
            logic                  stable_a;
            logic                  stable_b;

            // A level is taken only when the current sample and the previous
            // FILTER_LEN-1 samples all agree; otherwise the last accepted level holds.
            assign stable_a = (hist_a == {(FILTER_LEN-1){sa}});
            assign stable_b = (hist_b == {(FILTER_LEN-1){sb}});
            assign cur_a    = stable_a ? sa : acc_a;
            assign cur_b    = stable_b ? sb : acc_b;

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    hist_a <= '0;
                    hist_b <= '0;
                    acc_a  <= 1'b0;
                    acc_b  <= 1'b0;
                end else begin
                    hist_a[0] <= sa;
                    hist_b[0] <= sb;
                    for (int i = 1; i < FILTER_LEN-1; i++) begin
                        hist_a[i] <= hist_a[i-1];
                        hist_b[i] <= hist_b[i-1];
                    end
                    acc_a <= cur_a;
                    acc_b <= cur_b;
                end
            end
        end else begin : g_nofilt
            assign cur_a = sa;
            assign cur_b = sb;
        end
    endgenerate

    // Transitions keyed as {prev, cur} with each state written {A,B}.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev  <= 2'b00;
            count <= '0;
            dir   <= 1'b0;
            step  <= 1'b0;
            err   <= 1'b0;
        end else begin
            prev <= {cur_a, cur_b};
            step <= 1'b0;
            err  <= 1'b0;
            case ({prev, cur_a, cur_b})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
                    count <= count + 1'b1;
                    dir   <= 1'b1;
                    step  <= 1'b1;
                end
                4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                    count <= count - 1'b1;
                    dir   <= 1'b0;
                    step  <= 1'b1;
                end
                4'b0011, 4'b1100, 4'b1001, 4'b0110: begin
                    err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_gen.sv
// Bench for quad_gen: two instances (filter off / FILTER_LEN=3) checked every cycle against a history-based model.
module tb_quad_gen;

    localparam int W = 22;

    logic         clk = 1'b0;
    logic         nrst;
    logic         quadA;
    logic         quadB;
    logic [W-1:0] count0, count1;
    logic         dir0, dir1, step0, step1, err0, err1;

    int checks = 0;
    int errors = 0;
    int steps_seen = 0;
    int errs_seen = 0;

    quad_gen #(.WIDTH(W), .SYNC_STAGES(2), .FILTER_LEN(1)) dut0 (
        .clk(clk), .nrst(nrst), .quadA(quadA), .quadB(quadB),
        .count(count0), .dir(dir0), .step(step0), .err(err0)
    );

    quad_gen #(.WIDTH(W), .SYNC_STAGES(2), .FILTER_LEN(3)) dut1 (
        .clk(clk), .nrst(nrst), .quadA(quadA), .quadB(quadB),
        .count(count1), .dir(dir1), .step(step1), .err(err1)
    );

    always #5 clk = ~clk;

    // Reference model: raw input history sampled at each rising edge; the decoder
    // sees the sample taken two edges earlier, filtered over FILTER_LEN samples.
    bit           ha [0:15];
    bit           hb [0:15];
    bit           m_acc_a [2];
    bit           m_acc_b [2];
    int           m_prev  [2];
    logic [W-1:0] m_cnt   [2];
    bit           m_dir   [2];
    bit           m_step  [2];
    bit           m_err   [2];

    // Position of a state along the up sequence 00 -> 10 -> 11 -> 01.
    function automatic int pos_of(bit a, bit b);
        if (!a && !b) return 0;
        if (a && !b)  return 1;
        if (a && b)   return 2;
        return 3;
    endfunction

    always @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < 16; i++) begin
                ha[i] = 1'b0;
                hb[i] = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                m_acc_a[k] = 1'b0; m_acc_b[k] = 1'b0; m_prev[k] = 0;
                m_cnt[k] = '0; m_dir[k] = 1'b0; m_step[k] = 1'b0; m_err[k] = 1'b0;
            end
        end else begin
            for (int i = 15; i > 0; i--) begin
                ha[i] = ha[i-1];
                hb[i] = hb[i-1];
            end
            ha[0] = quadA;
            hb[0] = quadB;
            for (int k = 0; k < 2; k++) begin
                automatic int  flen = (k == 0) ? 1 : 3;
                automatic bit  agree_a = 1'b1;
                automatic bit  agree_b = 1'b1;
                automatic int  p;
                automatic int  d;
                for (int j = 1; j < flen; j++) begin
                    if (ha[2+j] != ha[2]) agree_a = 1'b0;
                    if (hb[2+j] != hb[2]) agree_b = 1'b0;
                end
                if (agree_a) m_acc_a[k] = ha[2];
                if (agree_b) m_acc_b[k] = hb[2];
                p = pos_of(m_acc_a[k], m_acc_b[k]);
                d = (p - m_prev[k] + 4) % 4;
                m_step[k] = (d == 1) || (d == 3);
                m_err[k]  = (d == 2);
                if (d == 1) begin m_cnt[k] = m_cnt[k] + 1; m_dir[k] = 1'b1; end
                if (d == 3) begin m_cnt[k] = m_cnt[k] - 1; m_dir[k] = 1'b0; end
                m_prev[k] = p;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("count0", 32'(count0), 32'(m_cnt[0]));
            chk("dir0",   32'(dir0),   32'(m_dir[0]));
            chk("step0",  32'(step0),  32'(m_step[0]));
            chk("err0",   32'(err0),   32'(m_err[0]));
            chk("count1", 32'(count1), 32'(m_cnt[1]));
            chk("dir1",   32'(dir1),   32'(m_dir[1]));
            chk("step1",  32'(step1),  32'(m_step[1]));
            chk("err1",   32'(err1),   32'(m_err[1]));
            if (step0) steps_seen++;
            if (err0)  errs_seen++;
        end
    endtask

    task automatic move(input bit up, input int dwell);
        automatic int p = (pos_of(quadA, quadB) + (up ? 1 : 3)) % 4;
        quadA = (p == 1) || (p == 2);
        quadB = (p == 2) || (p == 3);
        hold(dwell);
    endtask

    logic [W-1:0] saved;

    initial begin
        nrst  = 1'b0;
        quadA = 1'b0;
        quadB = 1'b0;

        // Inputs toggling under reset must not move anything.
        for (int i = 0; i < 8; i++) begin
            quadA = 1'($urandom_range(0, 1));
            quadB = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_count", 32'(count0), 32'd0);
            chk("rst_step",  32'(step0),  32'd0);
            chk("rst_err",   32'(err0),   32'd0);
        end
        quadA = 1'b0;
        quadB = 1'b0;
        nrst  = 1'b1;
        hold(4);
        chk("post_rst_count", 32'(count0), 32'd0);

        // First forward step: update lands on the third rising edge.
        steps_seen = 0;
        errs_seen  = 0;
        quadA = 1'b1;
        hold(2);
        chk("lat_before", 32'(count0), 32'd0);
        hold(1);
        chk("lat_at", 32'(count0), 32'd1);
        for (int i = 0; i < 39; i++) move(1'b1, 2);
        hold(3);
        chk("fwd_count", 32'(count0), 32'd40);
        chk("fwd_dir",   32'(dir0),   32'd1);
        chk("fwd_steps", 32'(steps_seen), 32'd40);

        for (int i = 0; i < 40; i++) move(1'b0, 2);
        hold(3);
        chk("rev_count", 32'(count0), 32'd0);
        chk("rev_dir",   32'(dir0),   32'd0);
        chk("rev_steps", 32'(steps_seen), 32'd80);
        chk("rev_errs",  32'(errs_seen),  32'd0);

        move(1'b0, 4);
        chk("wrap_down", 32'(count0), 32'h3FFFFF);
        move(1'b1, 4);
        chk("wrap_up", 32'(count0), 32'd0);

        // Both phases in one clock: single err pulse, no step, count held.
        steps_seen = 0;
        errs_seen  = 0;
        quadA = 1'b1;
        quadB = 1'b1;
        hold(5);
        chk("ill_errs",  32'(errs_seen),  32'd1);
        chk("ill_steps", 32'(steps_seen), 32'd0);
        chk("ill_count", 32'(count0), 32'd0);
        quadA = 1'b0;
        quadB = 1'b0;
        hold(5);
        chk("ill_back_errs", 32'(errs_seen), 32'd2);

        // Reset while resting at 11: release produces err against prev=00.
        move(1'b1, 4);
        move(1'b1, 4);
        nrst = 1'b0;
        @(negedge clk);
        chk("midrst_count", 32'(count0), 32'd0);
        nrst = 1'b1;
        errs_seen = 0;
        hold(5);
        chk("midrst_err",   32'(errs_seen), 32'd1);
        chk("midrst_count2", 32'(count0), 32'd0);

        move(1'b0, 6);
        move(1'b0, 6);
        saved = count1;
        quadA = 1'b1;
        hold(1);
        quadA = 1'b0;
        hold(6);
        chk("glitch_filt", 32'(count1), 32'(saved));
        quadA = 1'b1;
        hold(6);
        chk("filt_step", 32'(count1), 32'(saved + 1'b1));

        // Random walk including illegal jumps and short dwells.
        for (int i = 0; i < 400; i++) begin
            automatic int r = $urandom_range(0, 9);
            automatic int dw = $urandom_range(1, 5);
            if (r < 4) move(1'b1, dw);
            else if (r < 8) move(1'b0, dw);
            else if (r == 8) begin
                quadA = ~quadA;
                quadB = ~quadB;
                hold(dw);
            end else hold(dw);
        end
        hold(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_gen.md
Name: quad_gen

Overview:
- Quadrature (A/B) incremental-encoder decoder with x4 resolution.
- Synchronizes two asynchronous encoder phase inputs to the system clock and detects every valid Gray-code transition.
- Maintains a signed/wrapping position counter.
- Sits between the encoder input pins and position/velocity logic in the motor-control path.

Parameters:
- WIDTH, 22, width of the position counter `count`.
- SYNC_STAGES, 2, flip-flop synchronizer depth per phase input (minimum 2).
- FILTER_LEN, 1, consecutive identical synchronized samples required before a phase level is accepted (1 = filter disabled).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- quadA  input  1  encoder phase A, asynchronous to clk.
- quadB  input  1  encoder phase B, asynchronous to clk.
- count  output  WIDTH  position counter, two's-complement wrapping.
- dir  output  1  direction of last valid step (1 = up / A leads B, 0 = down).
- step  output  1  one-clk pulse on every valid count change.
- err  output  1  one-clk pulse on an illegal transition (both phases change in one sample).

Behaviour:
- Reset (nrst=0, async assert; release is sampled on clk):
  - count=0, dir=0, step=0, err=0.
  - All synchronizer flops, filter state and the previous-state register cleared to 0.
  - Decoder takes the state (A,B)=(0,0) as its start point.
- Synchronizer: each of quadA/quadB passes through a SYNC_STAGES-deep flop chain.
- Filter:
  - Accepted level changes only after FILTER_LEN consecutive equal synchronized samples.
  - With FILTER_LEN=1, accepted level = synchronizer output.
- Decoder:
  - Register prev=(A,B) holds the accepted state of the previous clock.
  - Compare prev against the current accepted state cur.
- Up sequence (A leads B): 00->10->11->01->00.
  - Each step: count <= count+1, dir <= 1, step pulse.
- Down sequence (B leads A): 00->01->11->10->00.
  - Each step: count <= count-1, dir <= 0, step pulse.
- cur == prev: no change; step=0, err=0.
- Both bits differ (00<->11, 10<->01):
  - count unchanged, dir unchanged.
  - err=1 for one cycle; step=0.
- Latency with defaults: a phase edge at the input is reflected in count exactly SYNC_STAGES+1 rising clk edges later (3 clocks); step/err are aligned with the count update.
- Wrap-around:
  - count increments modulo 2^WIDTH; 2^WIDTH-1 +1 -> 0.
  - 0 -1 -> 2^WIDTH-1.
  - No saturation, no flag.
- Direction reversal mid-cycle (e.g. 10->00 right after 00->10): the decrement is applied normally; there is no hysteresis.
- Minimum phase dwell for guaranteed counting: FILTER_LEN+1 clocks per Gray state. Shorter pulses may be dropped or flagged as err, never miscounted in the wrong direction.
- Reset mid-operation:
  - count returns to 0 immediately (async).
  - After release, the first accepted state is compared against prev=00. If the encoder rests at 11, that yields err with no count change.

Test Plan:
- Hold nrst=0, toggle quadA/quadB -> count=0, step=0, err=0 throughout. Release nrst with A=B=0 -> count stays 0.
- 10 forward cycles (A↑, B↑, A↓, B↓), each phase held 2 clk periods -> count steps 1..40, dir=1, 40 step pulses. Each update occurs 3 clocks after its input edge.
- Then 10 reverse cycles (B↑, A↑, B↓, A↓), 2 clk per phase -> count returns 40->0 in unit steps, dir=0, err never asserted.
- From count=0, one down step -> count=0x3FFFFF. Next up step -> count=0.
- Change quadA and quadB in the same clk (00->11) -> err pulses once, count unchanged, step=0.
- With FILTER_LEN=3: a 1-clk glitch on quadA -> no count change. A 4-clk-stable forward step -> count+1.
